// File: rtl/spart_bus_driver.sv
// Processor-side bus master for the spart: programs the baud divisor, then
// echoes every received byte back through a small FIFO.
module spart_bus_driver #(
    parameter int CLK_HZ     = 50000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    input  logic                          rda,
    input  logic                          tbr,
    output logic                          iocs,
    output logic                          iorw,
    output logic [1:0]                    ioaddr,
    inout  wire  [7:0]                    databus,
    output logic [7:0]                    rx_byte,
    output logic                          rx_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / 4800);
    localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / 9600);
    localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / 19200);
    localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / 38400);

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    state_t          state_q;
    logic            gap_to_hi_q;
    logic [1:0]      cfg_q;
    logic            iocs_q;
    logic            iorw_q;
    logic [1:0]      ioaddr_q;
    logic [7:0]      dout_q;
    logic [7:0]      rx_byte_q;
    logic            rx_strobe_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      mem [FIFO_DEPTH];

    logic [15:0]     div_cur;
    logic [15:0]     div_new;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic [7:0]      head;

    function automatic logic [15:0] div_sel(input logic [1:0] sel);
        case (sel)
            2'b00:   return DIV_4800;
            2'b01:   return DIV_9600;
            2'b10:   return DIV_19200;
            default: return DIV_38400;
        endcase
    endfunction

    always_comb begin
        div_cur    = div_sel(cfg_q);
        div_new    = div_sel(br_cfg);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        push       = (state_q == RD) && iocs_q && !rst;
        head       = mem[rd_ptr_q];
    end

    // FIFO storage is pure data; contents are meaningless once the pointers reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= databus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CFG_LO;
            gap_to_hi_q <= 1'b0;
            cfg_q       <= br_cfg;
            iocs_q      <= 1'b0;
            iorw_q      <= 1'b1;
            ioaddr_q    <= 2'b00;
            rx_byte_q   <= 8'h00;
            rx_strobe_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            rx_strobe_q <= 1'b0;
            case (state_q)
                CFG_LO: begin
                    // Coming out of reset the bus is still idle, so launch first
                    if (!iocs_q) begin
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b0;
                        ioaddr_q <= 2'b10;
                        dout_q   <= div_cur[7:0];
                    end else begin
                        iocs_q      <= 1'b0;
                        iorw_q      <= 1'b1;
                        ioaddr_q    <= 2'b00;
                        gap_to_hi_q <= 1'b1;
                        state_q     <= GAP;
                    end
                end
                CFG_HI: begin
                    iocs_q   <= 1'b0;
                    iorw_q   <= 1'b1;
                    ioaddr_q <= 2'b00;
                    state_q  <= GAP;
                end
                RD: begin
                    iocs_q      <= 1'b0;
                    iorw_q      <= 1'b1;
                    ioaddr_q    <= 2'b00;
                    rx_byte_q   <= databus;
                    rx_strobe_q <= 1'b1;
                    wr_ptr_q    <= wr_ptr_q + AW'(1);
                    count_q     <= count_q + CW'(1);
                    state_q     <= GAP;
                end
                WR: begin
                    iocs_q   <= 1'b0;
                    iorw_q   <= 1'b1;
                    ioaddr_q <= 2'b00;
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    count_q  <= count_q - CW'(1);
                    state_q  <= GAP;
                end
                GAP: begin
                    // rda/tbr may still reflect the previous access here
                    if (gap_to_hi_q) begin
                        gap_to_hi_q <= 1'b0;
                        iocs_q      <= 1'b1;
                        iorw_q      <= 1'b0;
                        ioaddr_q    <= 2'b11;
                        dout_q      <= div_cur[15:8];
                        state_q     <= CFG_HI;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if ((cfg_q != br_cfg) && fifo_empty && tbr) begin
                        cfg_q    <= br_cfg;
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b0;
                        ioaddr_q <= 2'b10;
                        dout_q   <= div_new[7:0];
                        state_q  <= CFG_LO;
                    end else if (rda && !fifo_full) begin
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b1;
                        ioaddr_q <= 2'b00;
                        state_q  <= RD;
                    end else if (!fifo_empty && tbr) begin
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b0;
                        ioaddr_q <= 2'b00;
                        dout_q   <= head;
                        state_q  <= WR;
                    end
                end
                default: begin
                    iocs_q   <= 1'b0;
                    iorw_q   <= 1'b1;
                    ioaddr_q <= 2'b00;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign databus    = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
    assign iocs       = iocs_q;
    assign iorw       = iorw_q;
    assign ioaddr     = ioaddr_q;
    assign rx_byte    = rx_byte_q;
    assign rx_strobe  = rx_strobe_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_spart_bus_driver.sv
// Directed bench for spart_bus_driver with a minimal spart bus model that
// serves queued receive bytes and logs every write and read cycle.
module tb_spart_bus_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    logic       tbr = 1'b1;
    wire        rda;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic [2:0] fifo_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // spart model: pending receive bytes plus an optional forced bus value
    logic [7:0] rx_mem [0:15];
    int         rx_head = 0;
    int         rx_tail = 0;
    logic       force_oe = 1'b0;
    logic [7:0] force_val = 8'h00;
    logic [3:0] rx_head_idx;
    wire  [7:0] model_val;

    assign rx_head_idx = rx_head[3:0];
    assign rda       = (rx_head != rx_tail);
    assign model_val = force_oe ? force_val : rx_mem[rx_head_idx];
    assign databus   = (force_oe || (iocs && iorw)) ? model_val : 8'hzz;

    logic [1:0] wr_addr [0:63];
    logic [7:0] wr_data [0:63];
    int         wr_cyc  [0:63];
    int         wr_n = 0;
    logic [1:0] rd_addr [0:63];
    logic [7:0] rd_data [0:63];
    int         rd_cyc  [0:63];
    int         rd_n = 0;
    int         cyc = 0;
    int         strobe_n = 0;
    int         proto_err = 0;
    logic       prev_iocs = 1'b0;

    spart_bus_driver #(
        .CLK_HZ     (50000000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .rx_byte    (rx_byte),
        .rx_strobe  (rx_strobe),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_iocs <= iocs && !rst;
        if (rx_strobe) strobe_n <= strobe_n + 1;
        if (!rst && iocs) begin
            if (prev_iocs) proto_err <= proto_err + 1;
            if (iorw) begin
                rd_addr[rd_n[5:0]] <= ioaddr;
                rd_data[rd_n[5:0]] <= databus;
                rd_cyc[rd_n[5:0]]  <= cyc;
                rd_n               <= rd_n + 1;
                if (rx_head != rx_tail) rx_head <= rx_head + 1;
            end else begin
                wr_addr[wr_n[5:0]] <= ioaddr;
                wr_data[wr_n[5:0]] <= databus;
                wr_cyc[wr_n[5:0]]  <= cyc;
                wr_n               <= wr_n + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_rx(input logic [7:0] v);
        rx_mem[rx_tail[3:0]] = v;
        rx_tail = rx_tail + 1;
    endtask

    task automatic test_reset;
        int b;
        rst = 1'b1; br_cfg = 2'b01; tbr = 1'b1;
        tick(3);
        chk_cnt++; if (iocs !== 1'b0) $display("FAIL reset_iocs got=%b want=0", iocs); else pass_cnt++;
        chk_cnt++; if (iorw !== 1'b1) $display("FAIL reset_iorw got=%b want=1", iorw); else pass_cnt++;
        chk_cnt++; if (ioaddr !== 2'b00) $display("FAIL reset_ioaddr got=%b want=00", ioaddr); else pass_cnt++;
        chk_cnt++; if (rx_byte !== 8'h00) $display("FAIL reset_rx_byte got=%h want=00", rx_byte); else pass_cnt++;
        chk_cnt++; if (rx_strobe !== 1'b0) $display("FAIL reset_rx_strobe got=%b want=0", rx_strobe); else pass_cnt++;
        chk_cnt++; if (fifo_count !== 3'd0) $display("FAIL reset_fifo_count got=%0d want=0", fifo_count); else pass_cnt++;
        b = wr_n;
        rst = 1'b0;
        for (int i = 0; i < 50 && wr_n < b + 2; i++) tick(1);
        chk_cnt++; if (wr_n < b + 2) $display("FAIL cfg_timeout writes=%0d want=%0d", wr_n - b, 2); else pass_cnt++;
        $display("cfg lo: addr=%b data=%h  cfg hi: addr=%b data=%h", wr_addr[b], wr_data[b], wr_addr[b+1], wr_data[b+1]);
        chk_cnt++; if (wr_addr[b] !== 2'b10 || wr_data[b] !== 8'h58) $display("FAIL cfg_lo got=%b/%h want=10/58", wr_addr[b], wr_data[b]); else pass_cnt++;
        chk_cnt++; if (wr_addr[b+1] !== 2'b11 || wr_data[b+1] !== 8'h14) $display("FAIL cfg_hi got=%b/%h want=11/14", wr_addr[b+1], wr_data[b+1]); else pass_cnt++;
        chk_cnt++; if (wr_cyc[b+1] - wr_cyc[b] !== 2) $display("FAIL cfg_gap got=%0d want=2", wr_cyc[b+1] - wr_cyc[b]); else pass_cnt++;
        tick(5);
        chk_cnt++; if (wr_n !== b + 2 || iocs !== 1'b0) $display("FAIL cfg_idle writes=%0d iocs=%b want=2/0", wr_n - b, iocs); else pass_cnt++;
        force_oe = 1'b1; force_val = 8'h5A;
        #1;
        chk_cnt++; if (databus !== 8'h5A) $display("FAIL idle_bus_release got=%h want=5a", databus); else pass_cnt++;
        force_oe = 1'b0;
        #1;
    endtask

    task automatic test_echo;
        int bw, br, bs;
        bw = wr_n; br = rd_n; bs = strobe_n;
        tbr = 1'b1;
        push_rx(8'h41);
        for (int i = 0; i < 50 && wr_n < bw + 1; i++) tick(1);
        tick(3);
        $display("echo: read %h, wrote addr=%b data=%h, fifo_count=%0d", rd_data[br], wr_addr[bw], wr_data[bw], fifo_count);
        chk_cnt++; if (rd_n !== br + 1 || rd_addr[br] !== 2'b00) $display("FAIL echo_reads got=%0d addr=%b want=1/00", rd_n - br, rd_addr[br]); else pass_cnt++;
        chk_cnt++; if (rx_byte !== 8'h41) $display("FAIL echo_rx_byte got=%h want=41", rx_byte); else pass_cnt++;
        chk_cnt++; if (strobe_n !== bs + 1) $display("FAIL echo_strobe got=%0d want=1", strobe_n - bs); else pass_cnt++;
        chk_cnt++; if (wr_n !== bw + 1 || wr_addr[bw] !== 2'b00 || wr_data[bw] !== 8'h41) $display("FAIL echo_write got=%0d %b/%h want=1 00/41", wr_n - bw, wr_addr[bw], wr_data[bw]); else pass_cnt++;
        chk_cnt++; if (wr_cyc[bw] - rd_cyc[br] < 2) $display("FAIL echo_gap got=%0d want>=2", wr_cyc[bw] - rd_cyc[br]); else pass_cnt++;
        chk_cnt++; if (fifo_count !== 3'd0) $display("FAIL echo_fifo_count got=%0d want=0", fifo_count); else pass_cnt++;
    endtask

    task automatic test_full;
        int bw, br;
        bw = wr_n; br = rd_n;
        tbr = 1'b0;
        for (int v = 1; v <= 5; v++) push_rx(8'(v));
        tick(40);
        $display("full: reads=%0d fifo_count=%0d rda=%b", rd_n - br, fifo_count, rda);
        chk_cnt++; if (rd_n !== br + 4) $display("FAIL full_reads got=%0d want=4", rd_n - br); else pass_cnt++;
        chk_cnt++; if (fifo_count !== 3'd4) $display("FAIL full_count got=%0d want=4", fifo_count); else pass_cnt++;
        chk_cnt++; if (rda !== 1'b1 || wr_n !== bw) $display("FAIL full_hold rda=%b writes=%0d want=1/0", rda, wr_n - bw); else pass_cnt++;
        tbr = 1'b1;
        for (int i = 0; i < 200 && wr_n < bw + 5; i++) tick(1);
        chk_cnt++; if (wr_n < bw + 5) $display("FAIL full_drain_timeout writes=%0d want=5", wr_n - bw); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            $display("drain write %0d: data=%h", k, wr_data[bw+k]);
            chk_cnt++; if (wr_data[bw+k] !== 8'(k + 1)) $display("FAIL full_order idx=%0d got=%h want=%h", k, wr_data[bw+k], 8'(k + 1)); else pass_cnt++;
        end
        chk_cnt++; if (rd_n !== br + 5 || rd_cyc[br+4] <= wr_cyc[bw]) $display("FAIL full_fifth_read reads=%0d rdcyc=%0d wrcyc=%0d", rd_n - br, rd_cyc[br+4], wr_cyc[bw]); else pass_cnt++;
        tick(3);
        chk_cnt++; if (fifo_count !== 3'd0) $display("FAIL full_empty got=%0d want=0", fifo_count); else pass_cnt++;
    endtask

    task automatic test_priority;
        int bw, br;
        tbr = 1'b0;
        push_rx(8'hA1);
        for (int i = 0; i < 30 && fifo_count != 3'd1; i++) tick(1);
        tick(3);
        bw = wr_n; br = rd_n;
        push_rx(8'hA2);
        tbr = 1'b1;
        for (int i = 0; i < 20 && rd_n == br && wr_n == bw; i++) tick(1);
        $display("priority: first access reads=%0d writes=%0d", rd_n - br, wr_n - bw);
        chk_cnt++; if (rd_n !== br + 1 || wr_n !== bw) $display("FAIL prio_read_first reads=%0d writes=%0d want=1/0", rd_n - br, wr_n - bw); else pass_cnt++;
        for (int i = 0; i < 50 && wr_n < bw + 2; i++) tick(1);
        chk_cnt++; if (wr_n !== bw + 2 || wr_data[bw] !== 8'hA1 || wr_data[bw+1] !== 8'hA2) $display("FAIL prio_writes got=%0d %h %h want=2 a1 a2", wr_n - bw, wr_data[bw], wr_data[bw+1]); else pass_cnt++;
    endtask

    task automatic test_baud;
        int bw;
        logic [1:0] ea [4];
        logic [7:0] ed [4];
        ea = '{2'b00, 2'b00, 2'b10, 2'b11};
        ed = '{8'h11, 8'h22, 8'h16, 8'h05};
        tbr = 1'b0;
        push_rx(8'h11);
        push_rx(8'h22);
        for (int i = 0; i < 30 && fifo_count != 3'd2; i++) tick(1);
        tick(3);
        bw = wr_n;
        br_cfg = 2'b11;
        tbr = 1'b1;
        for (int i = 0; i < 60 && wr_n < bw + 4; i++) tick(1);
        chk_cnt++; if (wr_n < bw + 4) $display("FAIL baud_timeout writes=%0d want=4", wr_n - bw); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            $display("baud write %0d: addr=%b data=%h", k, wr_addr[bw+k], wr_data[bw+k]);
            chk_cnt++; if (wr_addr[bw+k] !== ea[k] || wr_data[bw+k] !== ed[k]) $display("FAIL baud_seq idx=%0d got=%b/%h want=%b/%h", k, wr_addr[bw+k], wr_data[bw+k], ea[k], ed[k]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_wr;
        int bw;
        tbr = 1'b0;
        push_rx(8'h33);
        push_rx(8'h44);
        for (int i = 0; i < 30 && fifo_count != 3'd2; i++) tick(1);
        tick(3);
        tbr = 1'b1;
        for (int i = 0; i < 20 && !(iocs && !iorw); i++) tick(1);
        chk_cnt++; if (!(iocs === 1'b1 && iorw === 1'b0) || databus !== 8'h33) $display("FAIL rstwr_in_write iocs=%b iorw=%b bus=%h want=1/0/33", iocs, iorw, databus); else pass_cnt++;
        rst = 1'b1;
        tick(1);
        $display("reset mid-write: iocs=%b fifo_count=%0d", iocs, fifo_count);
        chk_cnt++; if (iocs !== 1'b0) $display("FAIL rstwr_iocs got=%b want=0", iocs); else pass_cnt++;
        chk_cnt++; if (fifo_count !== 3'd0) $display("FAIL rstwr_count got=%0d want=0", fifo_count); else pass_cnt++;
        force_oe = 1'b1; force_val = 8'hC0;
        #1;
        chk_cnt++; if (databus !== 8'hC0) $display("FAIL rstwr_bus_release got=%h want=c0", databus); else pass_cnt++;
        force_oe = 1'b0;
        #1;
        bw = wr_n;
        rst = 1'b0;
        for (int i = 0; i < 50 && wr_n < bw + 2; i++) tick(1);
        chk_cnt++; if (wr_n < bw + 2 || wr_addr[bw] !== 2'b10 || wr_data[bw] !== 8'h16) $display("FAIL rstwr_cfg_lo got=%b/%h want=10/16", wr_addr[bw], wr_data[bw]); else pass_cnt++;
        chk_cnt++; if (wr_addr[bw+1] !== 2'b11 || wr_data[bw+1] !== 8'h05) $display("FAIL rstwr_cfg_hi got=%b/%h want=11/05", wr_addr[bw+1], wr_data[bw+1]); else pass_cnt++;
        tick(20);
        chk_cnt++; if (wr_n !== bw + 2 || fifo_count !== 3'd0) $display("FAIL rstwr_discard writes=%0d count=%0d want=2/0", wr_n - bw, fifo_count); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_echo;
        test_full;
        test_priority;
        test_baud;
        test_reset_mid_wr;
        chk_cnt++; if (proto_err !== 0) $display("FAIL bus_back_to_back got=%0d want=0", proto_err); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
